if_prefetch_queue: RTL
======================

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC / fetch address width.
REQ-002 SHALL have parameter INSN_W, default 32: instruction width.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries; power of 2, >= 2.
REQ-004 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 SHALL have parameter PC_STEP, default 4: sequential PC increment.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port cpu_en, input, 1: fetch enable; 0 inhibits new requests only.
REQ-009 SHALL have port br_taken, input, 1: redirect/flush strobe.
REQ-010 SHALL have port br_addr, input, ADDR_W: redirect target.
REQ-011 SHALL have port imem_req, output, 1: fetch request valid.
REQ-012 SHALL have port imem_addr, output, ADDR_W: fetch address.
REQ-013 SHALL have port imem_gnt, input, 1: request accepted when imem_req && imem_gnt.
REQ-014 SHALL have port imem_rvalid, input, 1: response valid; responses return in order, >= 1 cycle after grant.
REQ-015 SHALL have port imem_rdata, input, INSN_W: response instruction.
REQ-016 SHALL have port if_en, output, 1: queue head valid.
REQ-017 SHALL have port if_pc, output, ADDR_W: PC of head entry.
REQ-018 SHALL have port if_insn, output, INSN_W: instruction of head entry.
REQ-019 SHALL have port id_ready, input, 1: decode accepts head when if_en && id_ready.

Function
REQ-020 SHALL hold fetch_pc; each grant SHALL advance fetch_pc by PC_STEP, modulo 2^ADDR_W, with wrap-around at the top.
REQ-021 SHALL drive imem_addr = fetch_pc.
REQ-022 SHALL assert imem_req iff cpu_en && !br_taken && (count + outstanding) < DEPTH, all values taken pre-edge; a same-cycle pop does not free a credit until the next cycle.
REQ-023 SHALL track outstanding (granted, not yet returned): +1 per grant, -1 per rvalid, both in the same cycle -> unchanged; range 0..DEPTH.
REQ-024 SHALL track in a per-request PC FIFO (depth DEPTH) the address of each granted request; on rvalid it SHALL pair the oldest PC with imem_rdata.
REQ-025 SHALL, on non-discarded rvalid, push {pc, rdata} into the queue; the credit rule guarantees no overflow.
REQ-026 SHALL drive if_en = (count != 0), and drive if_pc/if_insn = head entry when if_en = 1, else 0.
REQ-027 SHALL pop the head on if_en && id_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-028 SHALL, on br_taken: empty the queue and the PC FIFO, set fetch_pc = br_addr, load discard = outstanding - (rvalid ? 1 : 0), and ignore any same-cycle pop, push or grant.
REQ-029 SHALL drop each rvalid while discard != 0 and decrement discard; a second br_taken SHALL reload discard per REQ-028.
REQ-030 SHALL issue the first post-redirect request (to br_addr) in the cycle after br_taken at the earliest.
REQ-031 SHALL, with cpu_en = 0, issue no request, still accept responses, keep the queue poppable, and keep fetch_pc unchanged.
REQ-032 SHALL use widths: count 0..DEPTH, outstanding 0..DEPTH, discard 0..DEPTH, each log2(DEPTH)+1 bits.

Reset
REQ-033 SHALL, while reset = 1 at a clock edge, set fetch_pc = RESET_PC and count = outstanding = discard = 0; outputs then read imem_req = 0, if_en = 0, if_pc = 0, if_insn = 0.
REQ-034 SHALL drop any response to a pre-reset request arriving after reset is released; the memory side is reset together with this block.
REQ-035 SHALL give reset priority over br_taken and cpu_en.

Verification
REQ-036 Bench SHALL cover: reset, cpu_en = 1, gnt = 1, 1-cycle latency, id_ready = 1 -> if_pc sequence 0, 4, 8, 12 on consecutive cycles from cycle 2.
REQ-037 Bench SHALL cover: id_ready = 0, DEPTH = 4 -> exactly 4 grants, then imem_req = 0; count = 4; head stays pc = 0.
REQ-038 Bench SHALL cover: 2 requests outstanding, br_taken with br_addr = 0x100 -> both responses dropped, next if_pc = 0x100, then 0x104.
REQ-039 Bench SHALL cover: br_taken in the same cycle as rvalid and pop -> the queue is empty next cycle, discard = outstanding - 1, and no stale if_en.
REQ-040 Bench SHALL cover: fetch_pc = 0xFFFFFFFC, grant -> next imem_addr = 0x00000000.
REQ-041 Bench SHALL cover: cpu_en dropped with 1 request outstanding -> its response is queued, there is no further imem_req, and fetch_pc holds.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch requests, in-order
// responses paired with their PCs, and redirect flush with response discard.
module if_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSN_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              if_en,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INSN_W-1:0] if_insn,
  input  logic              id_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;

  entry_t            q_mem [DEPTH];
  logic [PW-1:0]     q_head;
  logic [PW-1:0]     q_tail;
  logic [ADDR_W-1:0] pcf_mem [DEPTH];
  logic [PW-1:0]     pcf_rd;
  logic [PW-1:0]     pcf_wr;

  logic [CW:0] used;
  logic        grant;
  logic        rsp;
  logic        drop;
  logic        push;
  logic        pop;

  assign used = {1'b0, count} + {1'b0, outstanding};

  assign imem_req  = !reset && cpu_en && !br_taken && (used < DEPTH_W);
  assign imem_addr = fetch_pc;

  // Responses with nothing outstanding belong to a pre-reset request.
  assign grant = imem_req && imem_gnt;
  assign rsp   = imem_rvalid && (outstanding != '0);
  assign drop  = rsp && (discard != '0);
  assign push  = rsp && !drop && !br_taken;
  assign pop   = if_en && id_ready && !br_taken;

  assign if_en   = (count != '0);
  assign if_pc   = if_en ? q_mem[q_head].pc : '0;
  assign if_insn = if_en ? q_mem[q_head].insn : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      pcf_rd      <= '0;
      pcf_wr      <= '0;
    end else if (br_taken) begin
      fetch_pc    <= br_addr;
      count       <= '0;
      outstanding <= outstanding - CW'(rsp);
      discard     <= outstanding - CW'(rsp);
      q_head      <= '0;
      q_tail      <= '0;
      pcf_rd      <= '0;
      pcf_wr      <= '0;
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + STEP_W;
        pcf_wr   <= pcf_wr + 1'b1;
      end
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
      count       <= count + CW'(push) - CW'(pop);
      if (drop)
        discard <= discard - 1'b1;
      if (push) begin
        q_tail <= q_tail + 1'b1;
        pcf_rd <= pcf_rd + 1'b1;
      end
      if (pop)
        q_head <= q_head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      q_mem[q_tail] <= '{pc: pcf_mem[pcf_rd], insn: imem_rdata};
    if (grant)
      pcf_mem[pcf_wr] <= fetch_pc;
  end

endmodule
